// File: rtl/dot_product_stream.sv
// dot_product_stream: streaming signed dot product, one (x,w) pair per beat, N beats per result
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_x/in_w/in_last element stream;
//        out_valid/out_ready/out_dp/out_err result stream (out_err = in_last framing mismatch)
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
module dot_product_stream #(
  parameter int N      = 4,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ACC_W  = `ACC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_dp,
  output logic                     out_err
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [2*DATA_W-1:0] prod;
  logic [CW-1:0] cnt;
  logic err, err_nx, fire, last_beat;
  assign prod      = in_x * in_w;
  assign sum       = acc + ACC_W'(prod);
  assign last_beat = cnt == CW'(N - 1);
  assign fire      = in_valid & in_ready;
  assign err_nx    = err | (in_last != last_beat);
  always_comb begin
    in_ready  = state == ACCUM;
    out_valid = state == DONE;
    state_nx  = state;
    if (fire && last_beat) state_nx = DONE;
    else if (out_valid && out_ready) state_nx = ACCUM;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCUM;
    else state <= state_nx;
  // the Nth beat closes the vector regardless of in_last; in_last only feeds the error flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      out_dp  <= '0;
      out_err <= 1'b0;
    end else if (fire) begin
      if (last_beat) begin
        out_dp  <= sum;
        out_err <= err_nx;
        acc     <= '0;
        cnt     <= '0;
        err     <= 1'b0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
        err <= err_nx;
      end
    end
endmodule

// File: tb/tb_dot_product_stream.sv
// tb_dot_product_stream: randomized and directed checks of dot_product_stream against a behavioural model
module tb_dot_product_stream;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic signed [7:0] in_x = '0, in_w = '0;
  logic in_ready, out_valid, out_err;
  logic signed [31:0] out_dp;
  int checks = 0, failures = 0;
  bit rnd_phase = 1'b0;
  logic [32:0] got[$];
  dot_product_stream #(.N(N), .DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_dp(out_dp), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  int  m_sum, m_cnt, m_dp;
  bit  m_err, m_derr, m_pend;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_sum = 0; m_cnt = 0; m_err = 0; m_pend = 0; m_dp = 0; m_derr = 0;
    end else if (m_pend) begin
      if (out_ready) m_pend = 0;
    end else if (in_valid) begin
      m_sum += int'(in_x) * int'(in_w);
      m_err |= (in_last != (m_cnt == N - 1));
      m_cnt++;
      if (m_cnt == N) begin
        m_dp = m_sum; m_derr = m_err; m_pend = 1;
        m_sum = 0; m_cnt = 0; m_err = 0;
      end
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("in_ready", in_ready, !m_pend);
      chk("out_valid", out_valid, m_pend);
      if (m_pend) begin
        chk("out_dp", out_dp, m_dp);
        chk("out_err", out_err, m_derr);
      end
      if (out_valid && out_ready) got.push_back({out_err, out_dp});
    end
  task automatic send_beat(logic signed [7:0] x, logic signed [7:0] w, logic last);
    bit taken;
    in_valid = 1'b1; in_x = x; in_w = w; in_last = last;
    for (int t = 0; t < 60; t++) begin
      taken = in_ready;
      @(posedge clk); #1;
      if (taken) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("beat_accept_timeout", 0, 1);
  endtask
  task automatic send_vec(logic [31:0] xs, logic [31:0] ws, logic [3:0] lm, int gap);
    for (int i = 0; i < N; i++) begin
      send_beat(xs[8*i+:8], ws[8*i+:8], lm[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask
  task automatic expect_got(string name, logic [31:0] dp, logic err);
    logic [32:0] g;
    for (int t = 0; t < 20 && got.size() == 0; t++) begin @(posedge clk); #1; end
    if (got.size() == 0) begin
      chk({name, "_missing"}, 0, 1);
      return;
    end
    g = got.pop_front();
    chk({name, "_dp"}, g[31:0], dp);
    chk({name, "_err"}, g[32], err);
  endtask
  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_dp", out_dp, 0);
    chk("rst_out_err", out_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    send_vec({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 4'b1000, 0);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_in_ready", in_ready, 0);
    expect_got("basic", 32'h46, 0);
    send_vec({8'd4, 8'd3, -8'sd2, -8'sd1}, {4{8'd2}}, 4'b1000, 0);
    send_vec({4{8'h80}}, {4{8'h80}}, 4'b1000, 0);
    expect_got("neg", 32'd8, 0);
    expect_got("min", 32'h10000, 0);
    out_ready = 1'b0;
    send_vec({4{8'd1}}, {4{8'd1}}, 4'b1000, 0);
    fork
      send_vec({8'd0, 8'd0, 8'd0, 8'd5}, {4{8'd3}}, 4'b1000, 0);
      begin
        repeat (5) begin @(posedge clk); #1; chk("hold_valid", out_valid, 1); chk("hold_dp", out_dp, 4); end
        out_ready = 1'b1;
      end
    join
    expect_got("hold_a", 32'd4, 0);
    expect_got("hold_b", 32'd15, 0);
    send_vec({4{8'd1}}, {4{8'd3}}, 4'b1000, 2);
    expect_got("bubble", 32'd12, 0);
    send_vec({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 4'b0010, 0);
    expect_got("frame_bad", 32'd10, 1);
    send_vec({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 4'b1000, 0);
    expect_got("frame_ok", 32'd10, 0);
    send_beat(8'd9, 8'd9, 1'b0);
    send_beat(8'd9, 8'd9, 1'b0);
    rst_n = 1'b0; #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_dp", out_dp, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_vec({4{8'd2}}, {4{8'd2}}, 4'b1000, 0);
    expect_got("after_abort", 32'd16, 0);
    out_ready = 1'b0;
    send_vec({4{8'd7}}, {4{8'd7}}, 4'b1000, 0);
    @(posedge clk); #1;
    chk("done_valid", out_valid, 1);
    rst_n = 1'b0; #1;
    chk("done_abort_valid", out_valid, 0);
    chk("done_abort_err", out_err, 0);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    got.delete();
    rnd_phase = 1'b1;
    fork
      for (int v = 0; v < 40; v++)
        send_vec($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1000, $urandom_range(0, 2));
      while (rnd_phase) begin
        @(posedge clk); #1;
        out_ready = $urandom_range(0, 2) != 0;
      end
      begin
        repeat (3000) @(posedge clk);
        rnd_phase = 1'b0;
      end
    join_any
    rnd_phase = 1'b0;
    #1 out_ready = 1'b1;
    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
